// File: rtl/rf_buffer_seq.sv
// rf_buffer_seq: block transfer sequencer between a 256x12 buffer RAM and a
// pair of 12-bit word streams. A command moves 1..256 words starting at a
// buffer address, either from the inbound stream into the RAM (write) or
// from the RAM out to the outbound stream (read). Addresses wrap mod 256.
module rf_buffer_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic        cmd_dir,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_count,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [7:0]  ram_a,
  output logic [11:0] ram_din,
  output logic        ram_ce,
  output logic        ram_we,
  input  logic [11:0] ram_dout,
  input  logic [11:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [11:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_LAT,
    RD_OUT,
    DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  addr, addr_nxt;
  logic [8:0]  remaining, remaining_nxt;
  logic [11:0] rd_data_nxt;

  // State, address, word counter and outbound data register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      rd_data   <= '0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= remaining_nxt;
      rd_data   <= rd_data_nxt;
    end
  end

  // Next-state logic and all handshake / RAM control outputs.
  // Abort wins over a simultaneous write or handshake: no RAM write,
  // no counter movement, no done pulse.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    remaining_nxt = remaining;
    rd_data_nxt   = rd_data;
    busy          = 1'b0;
    done          = 1'b0;
    ram_a         = '0;
    ram_din       = '0;
    ram_ce        = 1'b0;
    ram_we        = 1'b0;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_start) begin
          addr_nxt      = cmd_addr;
          remaining_nxt = (cmd_count == 8'd0) ? 9'd256 : {1'b0, cmd_count};
          state_nxt     = cmd_dir ? WR : RD_REQ;
        end
      end

      WR: begin
        busy     = 1'b1;
        wr_ready = 1'b1;
        ram_a    = addr;
        if (abort) begin
          state_nxt = IDLE;
        end else if (wr_valid) begin
          ram_ce        = 1'b1;
          ram_we        = 1'b1;
          ram_din       = wr_data;
          addr_nxt      = addr + 8'd1;
          remaining_nxt = remaining - 9'd1;
          if (remaining == 9'd1) begin
            state_nxt = DONE;
          end
        end
      end

      RD_REQ: begin
        busy      = 1'b1;
        ram_ce    = 1'b1;
        ram_a     = addr;
        state_nxt = abort ? IDLE : RD_LAT;
      end

      RD_LAT: begin
        busy        = 1'b1;
        rd_data_nxt = ram_dout;
        state_nxt   = abort ? IDLE : RD_OUT;
      end

      RD_OUT: begin
        busy     = 1'b1;
        rd_valid = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (rd_ready) begin
          addr_nxt      = addr + 8'd1;
          remaining_nxt = remaining - 9'd1;
          state_nxt     = (remaining == 9'd1) ? DONE : RD_REQ;
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rf_buffer_seq.sv
// tb_rf_buffer_seq: directed scenarios followed by randomized traffic for
// rf_buffer_seq, with a RAM model and a transfer-level reference model.
module tb_rf_buffer_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [7:0]  cmd_count = '0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [7:0]  ram_a;
  logic [11:0] ram_din;
  logic        ram_ce, ram_we;
  logic [11:0] ram_dout = '0;
  logic [11:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [11:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;

  rf_buffer_seq dut (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_addr(cmd_addr), .cmd_count(cmd_count),
    .abort(abort), .busy(busy), .done(done),
    .ram_a(ram_a), .ram_din(ram_din), .ram_ce(ram_ce), .ram_we(ram_we), .ram_dout(ram_dout),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Buffer RAM: synchronous write, registered read; bench-side preload port.
  logic [11:0] mem [0:255];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_a = '0;
  logic [11:0] pre_d = '0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (ram_ce) begin
      if (ram_we) mem[ram_a] <= ram_din;
      else ram_dout <= mem[ram_a];
    end
  end

  // Transfer-level reference: phase, next word address, words left, and for
  // reads the number of cycles until the requested word is presented.
  typedef enum {M_IDLE, M_WR, M_RD, M_DONE} mphase_t;
  mphase_t mode = M_IDLE;
  int m_addr = 0;
  int m_left = 0;
  int m_wait = 0;

  always @(posedge clk) begin
    if (!reset) begin
      mode   = M_IDLE;
      m_left = 0;
    end else begin
      case (mode)
        M_IDLE: if (cmd_start) begin
          m_addr = int'(cmd_addr);
          m_left = (cmd_count == 8'd0) ? 256 : int'(cmd_count);
          m_wait = 2;
          mode   = cmd_dir ? M_WR : M_RD;
        end
        M_WR: begin
          if (abort) mode = M_IDLE;
          else if (wr_valid) begin
            m_addr = (m_addr + 1) % 256;
            m_left = m_left - 1;
            if (m_left == 0) mode = M_DONE;
          end
        end
        M_RD: begin
          if (abort) mode = M_IDLE;
          else if (m_wait > 0) m_wait = m_wait - 1;
          else if (rd_ready) begin
            m_addr = (m_addr + 1) % 256;
            m_left = m_left - 1;
            m_wait = 2;
            if (m_left == 0) mode = M_DONE;
          end
        end
        default: mode = M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of DUT outputs against the reference.
  always @(negedge clk) begin
    logic w, rq, ro, wg;
    if (!reset) begin
      chk("reset_outputs",
          64'({busy, done, wr_ready, rd_valid, ram_ce, ram_we, ram_a, ram_din, rd_data}), 64'd0);
    end else begin
      w  = (mode == M_WR);
      rq = (mode == M_RD) && (m_wait == 2);
      ro = (mode == M_RD) && (m_wait == 0);
      wg = w && wr_valid && !abort;
      chk("ctrl", 64'({busy, done, wr_ready, rd_valid, ram_ce, ram_we}),
          64'({w || (mode == M_RD), mode == M_DONE, w, ro, wg || rq, wg}));
      if (wg || rq) chk("ram_a", 64'(ram_a), 64'(m_addr[7:0]));
      if (wg) chk("ram_din", 64'(ram_din), 64'(wr_data));
      if (ro) chk("rd_data", 64'(rd_data), 64'(mem[m_addr[7:0]]));
    end
    if (ram_ce && ram_we) wr_cnt++;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic dir, input logic [7:0] a, input logic [7:0] n);
    cmd_start = 1'b1;
    cmd_dir   = dir;
    cmd_addr  = a;
    cmd_count = n;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [11:0] d);
    pre_en = 1'b1;
    pre_a  = a;
    pre_d  = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!rd_valid && n < 10) begin
      tick();
      n++;
    end
    chk(nm, 64'(rd_valid), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0;
    #1 reset = 1'b0;
    pre_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pre_a = 8'(i);
      pre_d = 12'($urandom);
      tick();
    end
    pre_en = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_rd_data", 64'(rd_data), 64'd0);

    // Write burst across 0o370..0o372
    w0 = wr_cnt; d0 = done_cnt;
    start(1'b1, 8'o370, 8'd3);
    wr_valid = 1'b1;
    wr_data = 12'o1111; tick();
    wr_data = 12'o2222; tick();
    wr_data = 12'o3333; tick();
    wr_valid = 1'b0;
    chk("burst_done", 64'(done), 64'd1);
    tick();
    chk("burst_idle", 64'({busy, done}), 64'd0);
    chk("burst_m370", 64'(mem[8'o370]), 64'(12'o1111));
    chk("burst_m371", 64'(mem[8'o371]), 64'(12'o2222));
    chk("burst_m372", 64'(mem[8'o372]), 64'(12'o3333));
    chk("burst_wr_cnt", 64'(wr_cnt - w0), 64'd3);
    chk("burst_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Read with backpressure
    preload(8'd5, 12'o7070);
    preload(8'd6, 12'o0707);
    d0 = done_cnt;
    rd_ready = 1'b0;
    start(1'b0, 8'd5, 8'd2);
    wait_valid("bp_valid1");
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold", 64'({rd_valid, rd_data}), 64'({1'b1, 12'o7070}));
      tick();
    end
    rd_ready = 1'b1;
    tick();
    wait_valid("bp_valid2");
    chk("bp_word2", 64'(rd_data), 64'(12'o0707));
    tick();
    rd_ready = 1'b0;
    chk("bp_done", 64'(done), 64'd1);
    tick();
    chk("bp_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Count 0 means 256 words, starting at 0o377 and wrapping
    w0 = wr_cnt; d0 = done_cnt;
    start(1'b1, 8'o377, 8'd0);
    wr_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) chk("wrap_busy_before_last", 64'({busy, done}), 64'b10);
      wr_data = 12'(i);
      tick();
    end
    wr_valid = 1'b0;
    chk("wrap_done", 64'(done), 64'd1);
    chk("wrap_first", 64'(mem[8'd255]), 64'd0);
    chk("wrap_second", 64'(mem[8'd0]), 64'd1);
    chk("wrap_last", 64'(mem[8'd254]), 64'd255);
    tick();
    chk("wrap_wr_cnt", 64'(wr_cnt - w0), 64'd256);
    chk("wrap_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("wrap_idle", 64'(busy), 64'd0);

    // Abort during the second word of a 4-word read
    d0 = done_cnt;
    rd_ready = 1'b1;
    start(1'b0, 8'd20, 8'd4);
    wait_valid("abort_valid1");
    tick();
    wait_valid("abort_valid2");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    rd_ready = 1'b0;
    chk("abort_idle", 64'({busy, rd_valid}), 64'd0);
    tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    start(1'b1, 8'd30, 8'd1);
    chk("abort_restart_busy", 64'(busy), 64'd1);
    wr_valid = 1'b1;
    wr_data = 12'o4321;
    tick();
    wr_valid = 1'b0;
    chk("abort_restart_done", 64'(done), 64'd1);
    tick();
    chk("abort_restart_mem", 64'(mem[8'd30]), 64'(12'o4321));

    // Start while busy is ignored; reset mid-write clears everything
    start(1'b1, 8'd40, 8'd4);
    wr_valid = 1'b1;
    wr_data = 12'o5555;
    cmd_start = 1'b1; cmd_dir = 1'b0; cmd_addr = 8'd99; cmd_count = 8'd1;
    tick();
    cmd_start = 1'b0;
    chk("ignored_start", 64'({busy, wr_ready, ram_a}), 64'({1'b1, 1'b1, 8'd41}));
    tick();
    reset = 1'b0;
    #1;
    chk("reset_immediate",
        64'({busy, done, wr_ready, rd_valid, ram_ce, ram_we, ram_a, ram_din, rd_data}), 64'd0);
    w0 = wr_cnt;
    tick(); tick(); tick();
    chk("reset_no_writes", 64'(wr_cnt - w0), 64'd0);
    wr_valid = 1'b0;
    reset = 1'b1;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      cmd_start = ($urandom_range(0, 5) == 0);
      cmd_dir   = 1'($urandom_range(0, 1));
      cmd_addr  = 8'($urandom);
      cmd_count = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      abort     = ($urandom_range(0, 29) == 0);
      wr_valid  = ($urandom_range(0, 3) != 0);
      wr_data   = 12'($urandom);
      rd_ready  = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 599) != 0);
      tick();
    end
    cmd_start = 1'b0;
    abort = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
